// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead adder/subtractor. One GROUP-bit lookahead
// group is resolved per stage, with the group carry registered between stages.
module cla_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int NSTAGE = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_width_check
    $error("cla_pipe: WIDTH must be a multiple of GROUP");
  end

  typedef logic [WIDTH-1:0] word_t;

  // Returns {carry out, carry into MSB, sum}; every carry is a flat sum of products.
  function automatic logic [GROUP+1:0] cla_group(
    input logic [GROUP-1:0] x,
    input logic [GROUP-1:0] y,
    input logic             c0
  );
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             t;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      t = c0;
      for (int unsigned j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int unsigned j = 0; j <= i; j++) begin
        t = g[j];
        for (int unsigned m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[GROUP], c[GROUP-1], p ^ c[GROUP-1:0]};
  endfunction

  logic             w_en;
  word_t            w_x   [NSTAGE];
  word_t            w_y   [NSTAGE];
  logic             w_ci  [NSTAGE];
  logic             w_vi  [NSTAGE];
  logic [GROUP+1:0] w_grp [NSTAGE];

  word_t            r_sa  [NSTAGE];
  word_t            r_sb  [NSTAGE];
  logic             r_c   [NSTAGE];
  logic             r_v   [NSTAGE];
  logic             r_ovf;

  assign w_en     = !r_v[NSTAGE-1] || out_ready;
  assign in_ready = w_en;

  always_comb begin
    w_x[0]  = a;
    w_y[0]  = sub ? ~b : b;
    w_ci[0] = sub | cin;
    w_vi[0] = in_valid;
    for (int unsigned k = 1; k < NSTAGE; k++) begin
      w_x[k]  = r_sa[k-1];
      w_y[k]  = r_sb[k-1];
      w_ci[k] = r_c[k-1];
      w_vi[k] = r_v[k-1];
    end
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      w_grp[k] = cla_group(w_x[k][GROUP-1:0], w_y[k][GROUP-1:0], w_ci[k]);
    end
  end

  // The A word rotates right one group per stage and each group's sum enters at
  // the top, so the next group is always in the low slot and the final stage
  // holds the complete result in natural bit order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        r_v[k]  <= 1'b0;
        r_sa[k] <= '0;
        r_sb[k] <= '0;
        r_c[k]  <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_en) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        r_v[k] <= w_vi[k];
        if (w_vi[k]) begin
          r_sa[k] <= (w_x[k] >> GROUP) | (word_t'(w_grp[k][GROUP-1:0]) << (WIDTH - GROUP));
          r_sb[k] <= w_y[k] >> GROUP;
          r_c[k]  <= w_grp[k][GROUP+1];
        end
      end
      if (w_vi[NSTAGE-1]) begin
        r_ovf <= w_grp[NSTAGE-1][GROUP+1] ^ w_grp[NSTAGE-1][GROUP];
      end
    end
  end

  assign out_valid = r_v[NSTAGE-1];
  assign s         = r_sa[NSTAGE-1];
  assign cout      = r_c[NSTAGE-1];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_pipe.sv
// tb_cla_pipe: self-checking bench for cla_pipe (WIDTH=16, GROUP=4) against an
// arithmetic reference model and a FIFO scoreboard.
module tb_cla_pipe;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  int          n_chk;
  int          n_fail;
  logic [17:0] q[$];

  cla_pipe #(.WIDTH(16), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, s} from integer arithmetic on the operands.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic sb);
    logic [31:0] u;
    int          sres;
    logic        ov;
    if (sb) begin
      u    = 32'(x) + 32'd65536 - 32'(y);
      sres = int'($signed(x)) - int'($signed(y));
    end else begin
      u    = 32'(x) + 32'(y) + 32'(c);
      sres = int'($signed(x)) + int'($signed(y)) + int'(c);
    end
    ov = (sres > 32767) || (sres < -32768);
    return {ov, u[16], u[15:0]};
  endfunction

  // Called at posedge+1: drive inputs, sample at posedge+2, advance to next posedge+1.
  task automatic step(input logic v, input logic [15:0] ai, input logic [15:0] bi,
                      input logic ci, input logic si, input logic ordy,
                      output logic acc, output logic irdy, output logic took,
                      output logic [17:0] res);
    in_valid  = v;
    a         = ai;
    b         = bi;
    cin       = ci;
    sub       = si;
    out_ready = ordy;
    #1;
    irdy = in_ready;
    acc  = in_valid && in_ready;
    took = out_valid && out_ready;
    res  = {ovf, cout, s};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    #12;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (s !== 16'h0000) begin n_fail++; $display("FAIL reset_s: got %h expected 0000", s); end
    n_chk++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [15:0] ta [5];
    logic [15:0] tb [5];
    logic        tc [5];
    logic        ts [5];
    logic [15:0] es [5];
    logic        ec [5];
    logic        eo [5];
    logic        acc, irdy, took;
    logic [17:0] res, got;
    int unsigned lat;
    ta = '{16'h0001, 16'h0FFF, 16'hFFFF, 16'h7FFF, 16'h8000};
    tb = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001};
    tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    es = '{16'h0001, 16'h1000, 16'hFFFF, 16'h8000, 16'h7FFF};
    ec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    eo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int unsigned i = 0; i < 5; i++) begin
      step(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1, acc, irdy, took, res);
      n_chk++; if (acc !== 1'b1) begin n_fail++; $display("FAIL directed%0d_accept: got %b expected 1", i, acc); end
      lat = 0;
      got = '0;
      for (int unsigned n = 1; n <= 12 && lat == 0; n++) begin
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, irdy, took, res);
        if (took) begin lat = n; got = res; end
      end
      n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected 4", i, lat); end
      n_chk++; if (got[15:0] !== es[i]) begin n_fail++; $display("FAIL directed%0d_s: got %h expected %h", i, got[15:0], es[i]); end
      n_chk++; if (got[16] !== ec[i]) begin n_fail++; $display("FAIL directed%0d_cout: got %b expected %b", i, got[16], ec[i]); end
      n_chk++; if (got[17] !== eo[i]) begin n_fail++; $display("FAIL directed%0d_ovf: got %b expected %b", i, got[17], eo[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic        acc, irdy, took, v, c, sb;
    logic [15:0] x, y;
    logic [17:0] res, exp_r;
    int          got, last;
    q.delete();
    got  = 0;
    last = -1;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      v  = (cyc < 8);
      x  = 16'($urandom);
      y  = 16'($urandom);
      c  = 1'($urandom);
      sb = 1'($urandom);
      step(v, x, y, c, sb, 1'b1, acc, irdy, took, res);
      if (v) begin
        n_chk++; if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: cycle %0d got %b expected 1", cyc, acc); end
      end
      if (took) begin
        exp_r = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
        n_chk++; if (res !== exp_r) begin n_fail++; $display("FAIL b2b_result%0d: got %h expected %h", got, res, exp_r); end
        if (got > 0) begin
          n_chk++; if (cyc != last + 1) begin n_fail++; $display("FAIL b2b_consecutive: got cycle %0d expected %0d", cyc, last + 1); end
        end
        last = cyc;
        got++;
      end
      if (acc) q.push_back(model(x, y, c, sb));
    end
    n_chk++; if (got != 8 || q.size() != 0) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 8 (left %0d)", got, q.size()); end
  endtask

  task automatic test_backpressure();
    logic [15:0] xa [8];
    logic [15:0] xb [8];
    logic        xc [8];
    logic        xs [8];
    logic        acc, irdy, took, ordy, v;
    logic [17:0] res, exp_r, held;
    int          bi, got, idx;
    for (int unsigned i = 0; i < 8; i++) begin
      xa[i] = 16'($urandom); xb[i] = 16'($urandom); xc[i] = 1'($urandom); xs[i] = 1'($urandom);
    end
    q.delete();
    bi   = 0;
    got  = 0;
    held = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      ordy = !(cyc >= 6 && cyc <= 8);
      v    = (bi < 8);
      idx  = v ? bi : 0;
      step(v, xa[idx], xb[idx], xc[idx], xs[idx], ordy, acc, irdy, took, res);
      if (!ordy) begin
        n_chk++; if (irdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", cyc, irdy); end
        if (cyc == 6) held = res;
        else begin
          n_chk++; if (res !== held) begin n_fail++; $display("FAIL bp_hold: cycle %0d got %h expected %h", cyc, res, held); end
        end
      end
      if (took) begin
        exp_r = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
        n_chk++; if (res !== exp_r) begin n_fail++; $display("FAIL bp_result%0d: got %h expected %h", got, res, exp_r); end
        got++;
      end
      if (acc) begin
        q.push_back(model(xa[idx], xb[idx], xc[idx], xs[idx]));
        bi++;
      end
    end
    n_chk++; if (got != 8 || q.size() != 0) begin n_fail++; $display("FAIL bp_count: got %0d results expected 8 (left %0d)", got, q.size()); end
  endtask

  task automatic test_reset_mid();
    logic        acc, irdy, took, c, sb;
    logic [15:0] x, y;
    logic [17:0] res, got, exp_r;
    int          stale;
    int unsigned lat;
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b1, 16'($urandom) | 16'h0001, 16'($urandom), 1'b1, 1'b0, 1'b1, acc, irdy, took, res);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (s !== 16'h0000) begin n_fail++; $display("FAIL rstmid_s: got %h expected 0000", s); end
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    stale = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, irdy, took, res);
      if (took) stale++;
    end
    n_chk++; if (stale != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d results expected 0", stale); end
    x  = 16'($urandom);
    y  = 16'($urandom);
    c  = 1'($urandom);
    sb = 1'($urandom);
    exp_r = model(x, y, c, sb);
    step(1'b1, x, y, c, sb, 1'b1, acc, irdy, took, res);
    lat = 0;
    got = '0;
    for (int unsigned n = 1; n <= 12 && lat == 0; n++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, irdy, took, res);
      if (took) begin lat = n; got = res; end
    end
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected 4", lat); end
    n_chk++; if (got !== exp_r) begin n_fail++; $display("FAIL rstmid_result: got %h expected %h", got, exp_r); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
